switch_debounce_reader: RTL and testbench
=========================================

# switch_debounce_reader

Parametrised, memory-mapped switch input port for the MIPS single-cycle CPU. It sits behind the memory/IO decoder in place of the plain switch latch. It synchronises and debounces up to 32 board switches, latches per-bit change flags, and presents debounced levels and change flags to the CPU as 16-bit halfword registers. It raises a level interrupt request while any change flag is set.

## Interface
Parameters:
- SW_WIDTH, 24, number of switch inputs; legal range 17..32.
- TICK_DIV, 50000, clock cycles per debounce sample tick; minimum 1.
- DB_SAMPLES, 4, consecutive equal ticks required to accept a new level; legal range 2..16.

Ports (one clock; reset is synchronous and active-high):
- switclk  input  1  system clock; all state updates on its rising edge.
- switchrst  input  1  synchronous active-high reset.
- switchctl  input  1  chip select from the memory/IO decoder.
- switchread  input  1  read strobe from the controller.
- switchaddr  input  3  halfword register select within the switch window.
- switchrdata  output  16  registered read data to the CPU.
- switchirq  output  1  high while any change flag is set.
- switch_input  input  SW_WIDTH  raw, asynchronous board switches.

## Operation
- Synchroniser: two flops per bit, sync = switch_input delayed 2 cycles. Reset value 0.
- Prescaler: counter 0..TICK_DIV-1, wraps to 0. tick = 1 in the cycle the count equals TICK_DIV-1. With TICK_DIV=1, tick is constantly 1. Reset value 0.
- History: per bit, a (DB_SAMPLES-1)-deep shift register that shifts in sync[i] on each tick. Reset value all 0.
- Debounced level db[i]: on a tick, if sync[i] and all history bits equal sync[i] and db[i] != sync[i], then db[i] <= sync[i]. Otherwise db[i] holds. Reset value 0.
- Change flags chg[i]: set in the same edge that db[i] changes, for either direction. Cleared by a read of the corresponding flag register. Reset value 0.
- switchirq = |chg, combinational from the chg register. Reset value 0.
- Register map, read when switchctl && switchread:
  - 3'b000: db[15:0].
  - 3'b010: db[SW_WIDTH-1:16] zero-extended to 16 bits.
  - 3'b100: chg[15:0]; clears chg[15:0] after the read.
  - 3'b110: chg[SW_WIDTH-1:16] zero-extended; clears chg[SW_WIDTH-1:16] after the read.
  - Odd addresses: switchrdata holds and no flags are cleared.
- Read data is not written when there is no access (switchctl=0 or switchread=0). switchrdata holds its last value, and its reset value is 0.
- The block has no write registers. A write strobe is never decoded.

## Timing
- Read latency: switchrdata is updated at the rising edge that samples switchctl && switchread. It is valid from that edge onward and held until the next access.
- A read of a flag register returns the pre-clear value.
- Simultaneous set and clear: if db[i] changes in the same cycle as a clearing read of chg[i], chg[i] ends at 1. The returned data shows the old chg[i].
- A read of a flag register during back-to-back accesses returns 0 for bits that were cleared by the immediately preceding read.
- Input-to-db latency for a clean step: 2 sync cycles, plus the wait to the next tick, plus (DB_SAMPLES-1) further ticks. The maximum is 2 + DB_SAMPLES*TICK_DIV cycles.
- Bounce shorter than DB_SAMPLES consecutive ticks never changes db and never sets chg.
- Reset mid-operation: at the asserting edge, all state returns to its reset value (sync, prescaler, history, db, chg, switchrdata). switchirq drops in the same cycle.
- After reset release, with switch_input held at 1, db becomes 1 after the normal latency and chg sets. Switches held on at power-up therefore report one change.

## Test plan
Bench parameters: SW_WIDTH=24, TICK_DIV=4, DB_SAMPLES=3.
- Reset, then read address 0, 2, 4 and 6 -> each returns 16'h0000 and switchirq=0.
- Step switch_input to 24'hA5_1234 and wait 16 cycles. Then read 0 -> 16'h1234. Read 2 -> 16'h00A5. switchirq=1.
- Read 4 -> 16'h1234, then read 4 again -> 16'h0000. Read 6 -> 16'h00A5, after which switchirq=0.
- Toggle bit 0 every 4 cycles (one tick) for 40 cycles, starting from 0 and ending at 0 -> db[0] stays 0 and chg stays 0.
- Time a step on bit 3 so that db[3] changes on the same edge as a read of address 4 -> the read returns bit 3 = 0, chg[3] = 1 afterwards, and switchirq stays 1.
- Assert switchrst for one cycle mid-debounce (two ticks into a step) -> all outputs are 0 the next cycle. db then reaches the input value only after the full latency has elapsed again from release. Read address 1 -> switchrdata unchanged.

Source files
------------

// File: rtl/switch_debounce_reader_if.sv
// CPU-side bus of the switch port: chip select, read strobe, halfword select,
// registered read data and the change interrupt.
interface switch_debounce_reader_if;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 16;

  logic              switchctl;
  logic              switchread;
  logic [ADDR_W-1:0] switchaddr;
  logic [DATA_W-1:0] switchrdata;
  logic              switchirq;

  modport master (
    output switchctl, switchread, switchaddr,
    input  switchrdata, switchirq
  );

  modport slave (
    input  switchctl, switchread, switchaddr,
    output switchrdata, switchirq
  );
endinterface

// File: rtl/switch_debounce_reader.sv
// Memory-mapped switch port: two-flop synchroniser, tick-based debouncer,
// sticky per-bit change flags with read-to-clear, and a level interrupt.
module switch_debounce_reader #(
  parameter int unsigned SW_WIDTH   = 24,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned DB_SAMPLES = 4
) (
  input  logic                    switclk,
  input  logic                    switchrst,
  switch_debounce_reader_if.slave bus,
  input  logic [SW_WIDTH-1:0]     switch_input
);
  localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HIST_W = DB_SAMPLES - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [SW_WIDTH-1:0] sync_meta;
  logic [SW_WIDTH-1:0] sync;
  logic [CNT_W-1:0]    cnt;
  logic                tick;
  logic [HIST_W-1:0]   hist [SW_WIDTH];
  logic [SW_WIDTH-1:0] db;
  logic [SW_WIDTH-1:0] chg;
  logic [SW_WIDTH-1:0] db_upd;
  logic [SW_WIDTH-1:0] clr_mask;
  logic [31:0]         db_ext;
  logic [31:0]         chg_ext;
  logic                rd_en;
  logic [15:0]         rd_data_c;
  logic [15:0]         rdata;

  // A bit flips only when this tick and the previous DB_SAMPLES-1 ticks agree.
  always_comb begin
    tick   = (cnt == CNT_MAX);
    db_upd = '0;
    for (int i = 0; i < SW_WIDTH; i++) begin
      db_upd[i] = tick && (hist[i] == {HIST_W{sync[i]}}) && (db[i] != sync[i]);
    end
  end

  // Read decode; odd halfword addresses are ignored entirely.
  always_comb begin
    rd_en     = bus.switchctl && bus.switchread && !bus.switchaddr[0];
    db_ext    = 32'(db);
    chg_ext   = 32'(chg);
    rd_data_c = '0;
    clr_mask  = '0;
    case (bus.switchaddr[2:1])
      2'b00:   rd_data_c = db_ext[15:0];
      2'b01:   rd_data_c = db_ext[31:16];
      2'b10:   rd_data_c = chg_ext[15:0];
      default: rd_data_c = chg_ext[31:16];
    endcase
    if (rd_en && bus.switchaddr[2]) begin
      clr_mask = bus.switchaddr[1] ? SW_WIDTH'(32'hFFFF_0000) : SW_WIDTH'(32'h0000_FFFF);
    end
  end

  always_ff @(posedge switclk) begin
    if (switchrst) begin
      sync_meta <= '0;
      sync      <= '0;
      cnt       <= '0;
      db        <= '0;
      chg       <= '0;
      rdata     <= '0;
      for (int i = 0; i < SW_WIDTH; i++) begin
        hist[i] <= '0;
      end
    end else begin
      sync_meta <= switch_input;
      sync      <= sync_meta;
      cnt       <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        for (int i = 0; i < SW_WIDTH; i++) begin
          hist[i] <= HIST_W'({hist[i], sync[i]});
        end
      end
      db <= db ^ db_upd;
      // A new change wins over a same-cycle clearing read.
      chg <= (chg & ~clr_mask) | db_upd;
      if (rd_en) begin
        rdata <= rd_data_c;
      end
    end
  end

  assign bus.switchrdata = rdata;
  assign bus.switchirq   = |chg;
endmodule

// File: tb/tb_switch_debounce_reader.sv
// Scoreboard bench for switch_debounce_reader: reads push expected data/irq,
// a monitor pops and compares one cycle-fraction after each sampled read.
module tb_switch_debounce_reader;
  localparam int unsigned SW_WIDTH = 24;

  logic                clk = 1'b0;
  logic                rst;
  logic [SW_WIDTH-1:0] sw;

  switch_debounce_reader_if bus ();

  switch_debounce_reader #(
    .SW_WIDTH  (SW_WIDTH),
    .TICK_DIV  (4),
    .DB_SAMPLES(3)
  ) dut (
    .switclk     (clk),
    .switchrst   (rst),
    .bus         (bus),
    .switch_input(sw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        irq;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Edges since the last reset release; ticks land on multiples of 4.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at cyc %0d", name, cyc);
  endtask

  always @(posedge clk) begin
    if (!rst && bus.switchctl === 1'b1 && bus.switchread === 1'b1) begin
      #1;
      if (sb.size() == 0) begin
        timeout("unexpected_read");
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_data"}, 32'(bus.switchrdata), 32'(mon_e.data));
        chk({mon_e.name, "_irq"}, 32'(bus.switchirq), 32'(mon_e.irq));
      end
    end
  end

  task automatic rd(input logic [2:0] a, input logic [15:0] d, input logic irq, input string name);
    exp_t e;
    e.data = d;
    e.irq  = irq;
    e.name = name;
    sb.push_back(e);
    bus.switchctl  = 1'b1;
    bus.switchread = 1'b1;
    bus.switchaddr = a;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.switchctl  = 1'b0;
    bus.switchread = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc != target) begin
      if (n == 200) begin
        timeout("wait_cyc");
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_phase1();
    int n = 0;
    while ((cyc % 4) != 1) begin
      if (n == 20) begin
        timeout("wait_phase");
        return;
      end
      @(negedge clk);
      n++;
    end
  endtask

  int n0;

  initial begin
    rst            = 1'b1;
    sw             = '0;
    bus.switchctl  = 1'b0;
    bus.switchread = 1'b0;
    bus.switchaddr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("reset_rdata", 32'(bus.switchrdata), 32'h0);
    chk("reset_irq", 32'(bus.switchirq), 32'h0);
    rd(3'b000, 16'h0000, 1'b0, "rst_rd0");
    rd(3'b010, 16'h0000, 1'b0, "rst_rd2");
    rd(3'b100, 16'h0000, 1'b0, "rst_rd4");
    rd(3'b110, 16'h0000, 1'b0, "rst_rd6");
    idle();

    // Clean step, then read levels and drain flags
    sw = 24'hA5_1234;
    repeat (16) @(negedge clk);
    rd(3'b000, 16'h1234, 1'b1, "step_rd0");
    rd(3'b010, 16'h00A5, 1'b1, "step_rd2");
    rd(3'b100, 16'h1234, 1'b1, "step_rd4a");
    rd(3'b100, 16'h0000, 1'b1, "step_rd4b");
    rd(3'b110, 16'h00A5, 1'b0, "step_rd6");
    idle();

    // One-tick bounce on bit 0 must never be accepted
    for (int i = 0; i < 10; i++) begin
      sw[0] = ~sw[0];
      repeat (4) @(negedge clk);
    end
    repeat (16) @(negedge clk);
    rd(3'b100, 16'h0000, 1'b0, "bounce_chg");
    rd(3'b000, 16'h1234, 1'b0, "bounce_db0");
    idle();
    repeat (3) @(negedge clk);
    chk("idle_hold", 32'(bus.switchrdata), 32'h1234);

    // Bit 3 settles on the exact edge of a clearing read of address 4
    wait_phase1();
    n0 = cyc;
    sw[3] = 1'b1;
    wait_cyc(n0 + 10);
    rd(3'b100, 16'h0000, 1'b1, "coinc_rd4");
    idle();
    rd(3'b000, 16'h123C, 1'b1, "coinc_rd0");
    rd(3'b100, 16'h0008, 1'b0, "coinc_rd4b");
    idle();

    // Reset two ticks into a step, then full latency from release
    wait_phase1();
    n0 = cyc;
    sw = 24'h5A_0F0F;
    wait_cyc(n0 + 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_rdata", 32'(bus.switchrdata), 32'h0);
    chk("midrst_irq", 32'(bus.switchirq), 32'h0);
    wait_cyc(10);
    rd(3'b000, 16'h0000, 1'b0, "lat_e11");
    rd(3'b000, 16'h0000, 1'b1, "lat_e12");
    rd(3'b010, 16'h005A, 1'b1, "lat_rd2");
    rd(3'b000, 16'h0F0F, 1'b1, "lat_rd0");
    rd(3'b001, 16'h0F0F, 1'b1, "odd_hold");
    rd(3'b100, 16'h0F0F, 1'b1, "lat_rd4");
    rd(3'b110, 16'h005A, 1'b0, "lat_rd6");
    idle();

    repeat (3) @(negedge clk);
    if (sb.size() != 0) timeout("sb_not_drained");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
